dense_layer_seq: RTL and testbench
==================================

# dense_layer_seq

Sequencer for the dense (fully connected) layer datapath. For each output neuron it fetches the input vector from the feature buffer, 5 words per cycle into a 25-word slice. It pairs each slice with the matching 25-word kernel ROM row and issues {VecA, VecB, Bias} to the shared 51-word MAC unit. The MAC result is chained back as the bias of the next slice, and the final sum is written to the output buffer. It sits between the layer-enable chain, the input feature buffer, the weight/bias ROMs and the MAC calc unit.

## Interface
- N_IN, 100, input vector length; multiple of 25
- N_OUT, 10, number of output neurons
- IN_BASE, 0, first input-buffer word address
- OUT_BASE, 0, first output-buffer word address
- clk  in  1  single clock; everything on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- layer_en_i  in  1  start pulse; sampled only in IDLE
- layer_done_o  out  1  one-cycle pulse after last write
- data_from_buf_addr_o  out  160  5 lane read addresses; lane l at [32l+31:32l]
- data_from_buf_i  in  80  5 lane read data, 1-cycle latency; lane l at [16l+15:16l]
- kernel_addr_o  out  16  kernel ROM row address
- kernel_data_i  in  400  kernel row, 1-cycle latency; word k at [16k+15:16k]
- bias_addr_o  out  8  bias ROM address
- bias_data_i  in  16  bias, 1-cycle latency
- data_to_calc_o  out  816  VecA word k at [416+16k+15:416+16k], VecB word k at [16+16k+15:16+16k], bias at [15:0]
- calc_valid_o  out  1  one-cycle issue strobe
- data_from_calc_i  in  16  MAC result (bias + A·B, calc-unit arithmetic)
- calc_valid_i  in  1  result strobe
- output_buf_en_o  out  1  output-buffer write enable
- data_to_buf_o  out  16  write data
- data_to_buf_addr_o  out  32  write address

## Operation
- Counters: o (0..N_OUT-1), c (0..C-1, C=N_IN/25), beat b (0..5).
- IDLE: wait for layer_en_i=1. Then clear o and c, and go to FETCH.
- FETCH (6 cycles, b=0..5):
  - For b<5, lane l address = IN_BASE + 25c + 5b + l.
  - At b≥1, capture data_from_buf_i into slice words 5(b-1)..5(b-1)+4.
  - kernel_addr_o = o·C + c and bias_addr_o = o are held through FETCH.
- ISSUE (1 cycle):
  - calc_valid_o=1.
  - VecA = slice; VecB = kernel_data_i.
  - Bias = bias_data_i if c=0, else psum.
- WAIT: hold until calc_valid_i=1, then psum ← data_from_calc_i.
  - If c<C-1: c++, go to FETCH.
  - Otherwise go to WRITE.
- WRITE (1 cycle):
  - output_buf_en_o=1, data_to_buf_o=psum, data_to_buf_addr_o = OUT_BASE + o.
  - c←0.
  - If o=N_OUT-1, go to DONE; otherwise o++ and go to FETCH.
- DONE (1 cycle): layer_done_o=1, then go to IDLE.
- Ignored inputs:
  - layer_en_i outside IDLE.
  - calc_valid_i outside WAIT, including in ISSUE.
- data_to_calc_o holds its last issued value until the next ISSUE.
- Reset at any time: return to IDLE; counters, psum and slice cleared.

## Timing
- All outputs are registered.
- Reset value of every output is 0: strobes, addresses and data buses.
- Per slice: 6 (FETCH) + 1 (ISSUE) + W cycles, where W ≥ 1 is the number of WAIT cycles up to and including the calc_valid_i cycle.
- Per neuron: C slices + 1 WRITE cycle.
- Zero-wait calc: total = N_OUT·(8C+1) + 1 cycles from the first FETCH cycle to the DONE cycle. Defaults give 331.
- No back-to-back issues: at most one calc request is outstanding.
- A calc_valid_i pulse in the same cycle as reset assertion is discarded.

## Test plan
- Defaults, zero-wait calc model, start pulse:
  - 10 writes at addresses 0..9, each equal to the model dense output.
  - layer_done_o exactly 331 cycles after the first FETCH cycle.
- Calc returns after 5 WAIT cycles:
  - data_to_calc_o stable throughout WAIT, no extra calc_valid_o.
  - Per-neuron time is 4·(7+5)+1 = 49 cycles.
- Address check, N_IN=50, IN_BASE=200, neuron 1, slice 1:
  - Lane 3, beat 2 reads address 238.
  - kernel_addr_o = 3, bias used is psum, not the ROM bias.
- layer_en_i pulsed mid-run and spurious calc_valid_i in FETCH:
  - No restart, psum unchanged, outputs identical to a clean run.
- rst_n low during WAIT of neuron 4:
  - All outputs 0 asynchronously; a new start after release begins at o=0, address IN_BASE.

Source files
------------

// File: rtl/dense_layer_seq.sv
// Dense-layer sequencer: streams 25-word input slices and kernel rows into a shared MAC unit,
// chaining each partial sum as the next slice's bias, and writes one result per output neuron.
module dense_layer_seq #(
    parameter int unsigned N_IN     = 100,
    parameter int unsigned N_OUT    = 10,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         layer_en_i,
    output logic         layer_done_o,
    output logic [159:0] data_from_buf_addr_o,
    input  logic [79:0]  data_from_buf_i,
    output logic [15:0]  kernel_addr_o,
    input  logic [399:0] kernel_data_i,
    output logic [7:0]   bias_addr_o,
    input  logic [15:0]  bias_data_i,
    output logic [815:0] data_to_calc_o,
    output logic         calc_valid_o,
    input  logic [15:0]  data_from_calc_i,
    input  logic         calc_valid_i,
    output logic         output_buf_en_o,
    output logic [15:0]  data_to_buf_o,
    output logic [31:0]  data_to_buf_addr_o
);

    localparam int unsigned SliceW = 25;
    localparam int unsigned Lanes  = 5;
    localparam int unsigned C      = N_IN / SliceW;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StWrite,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    o_q, o_d;
    logic [15:0]    c_q, c_d;
    logic [2:0]     b_q, b_d;
    logic [15:0]    psum_q, psum_d;
    logic [399:0]   slice_q, slice_d;

    logic [159:0]   rd_addr_q, rd_addr_d;
    logic [15:0]    kern_addr_q, kern_addr_d;
    logic [7:0]     bias_addr_q, bias_addr_d;
    logic [815:0]   calc_data_q, calc_data_d;
    logic           calc_valid_q, calc_valid_d;
    logic           wr_en_q, wr_en_d;
    logic [15:0]    wr_data_q, wr_data_d;
    logic [31:0]    wr_addr_q, wr_addr_d;
    logic           done_q, done_d;

    // Control: state, counters, slice capture and partial-sum chaining.
    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        c_d     = c_q;
        b_d     = b_q;
        psum_d  = psum_q;
        slice_d = slice_q;

        unique case (state_q)
            StIdle: begin
                if (layer_en_i) begin
                    o_d     = '0;
                    c_d     = '0;
                    b_d     = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Read data lags the address by one cycle, so beat b holds words of beat b-1.
                if (b_q != 3'd0) begin
                    for (int l = 0; l < 5; l++) begin
                        slice_d[16*(5*(int'(b_q)-1)+l) +: 16] = data_from_buf_i[16*l +: 16];
                    end
                end
                if (b_q == 3'd5) begin
                    state_d = StIssue;
                end else begin
                    b_d = b_q + 3'd1;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (calc_valid_i) begin
                    psum_d = data_from_calc_i;
                    if (c_q != 16'(C - 1)) begin
                        c_d     = c_q + 16'd1;
                        b_d     = '0;
                        state_d = StFetch;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                c_d = '0;
                if (o_q == 16'(N_OUT - 1)) begin
                    state_d = StDone;
                end else begin
                    o_d     = o_q + 16'd1;
                    b_d     = '0;
                    state_d = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        rd_addr_d    = rd_addr_q;
        kern_addr_d  = kern_addr_q;
        bias_addr_d  = bias_addr_q;
        calc_data_d  = calc_data_q;
        calc_valid_d = 1'b0;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        done_d       = 1'b0;

        unique case (state_d)
            StFetch: begin
                kern_addr_d = 16'(32'(o_d) * C + 32'(c_d));
                bias_addr_d = o_d[7:0];
                if (b_d < 3'd5) begin
                    for (int l = 0; l < 5; l++) begin
                        rd_addr_d[32*l +: 32] = IN_BASE + SliceW * 32'(c_d)
                                              + Lanes * 32'(b_d) + 32'(l);
                    end
                end
            end
            StIssue: begin
                calc_valid_d = 1'b1;
                calc_data_d  = {slice_d, kernel_data_i, (c_q == 16'd0) ? bias_data_i : psum_q};
            end
            StWrite: begin
                wr_en_d   = 1'b1;
                wr_data_d = psum_d;
                wr_addr_d = OUT_BASE + 32'(o_d);
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            o_q          <= '0;
            c_q          <= '0;
            b_q          <= '0;
            psum_q       <= '0;
            slice_q      <= '0;
            rd_addr_q    <= '0;
            kern_addr_q  <= '0;
            bias_addr_q  <= '0;
            calc_data_q  <= '0;
            calc_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_q          <= o_d;
            c_q          <= c_d;
            b_q          <= b_d;
            psum_q       <= psum_d;
            slice_q      <= slice_d;
            rd_addr_q    <= rd_addr_d;
            kern_addr_q  <= kern_addr_d;
            bias_addr_q  <= bias_addr_d;
            calc_data_q  <= calc_data_d;
            calc_valid_q <= calc_valid_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            done_q       <= done_d;
        end
    end

    assign layer_done_o         = done_q;
    assign data_from_buf_addr_o = rd_addr_q;
    assign kernel_addr_o        = kern_addr_q;
    assign bias_addr_o          = bias_addr_q;
    assign data_to_calc_o       = calc_data_q;
    assign calc_valid_o         = calc_valid_q;
    assign output_buf_en_o      = wr_en_q;
    assign data_to_buf_o        = wr_data_q;
    assign data_to_buf_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: random ROM/buffer contents, a MAC responder with programmable
// latency, and a dot-product reference model; one default instance plus a small address instance.
module tb_dense_layer_seq;

    localparam int N_IN   = 100;
    localparam int N_OUT  = 10;
    localparam int C      = 4;
    localparam int N_IN2  = 50;
    localparam int N_OUT2 = 2;
    localparam int IN_B2  = 200;
    localparam int OUT_B2 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, en2, spur;
    logic [15:0] spur_data;
    int lat;
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] in_mem [0:511];
    logic [15:0] kmem [0:63][0:24];
    logic [15:0] bmem [0:15];

    // Instance 1 (defaults)
    logic         d1_done, d1_cvo, d1_cvi_in, d1_wen, d1_cvi;
    logic [159:0] d1_rd_addr;
    logic [79:0]  d1_rd_data;
    logic [15:0]  d1_kaddr, d1_bdata, d1_res_in, d1_res, d1_wdata;
    logic [399:0] d1_kdata;
    logic [7:0]   d1_baddr;
    logic [815:0] d1_cdata;
    logic [31:0]  d1_waddr;
    int           d1_cnt;

    // Instance 2 (N_IN=50, IN_BASE=200)
    logic         d2_done, d2_cvo, d2_cvi, d2_wen;
    logic [159:0] d2_rd_addr;
    logic [79:0]  d2_rd_data;
    logic [15:0]  d2_kaddr, d2_bdata, d2_res, d2_wdata;
    logic [399:0] d2_kdata;
    logic [7:0]   d2_baddr;
    logic [815:0] d2_cdata;
    logic [31:0]  d2_waddr;

    assign d1_cvi_in = d1_cvi | spur;
    assign d1_res_in = spur ? spur_data : d1_res;

    dense_layer_seq dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .layer_en_i           (en),
        .layer_done_o         (d1_done),
        .data_from_buf_addr_o (d1_rd_addr),
        .data_from_buf_i      (d1_rd_data),
        .kernel_addr_o        (d1_kaddr),
        .kernel_data_i        (d1_kdata),
        .bias_addr_o          (d1_baddr),
        .bias_data_i          (d1_bdata),
        .data_to_calc_o       (d1_cdata),
        .calc_valid_o         (d1_cvo),
        .data_from_calc_i     (d1_res_in),
        .calc_valid_i         (d1_cvi_in),
        .output_buf_en_o      (d1_wen),
        .data_to_buf_o        (d1_wdata),
        .data_to_buf_addr_o   (d1_waddr)
    );

    dense_layer_seq #(
        .N_IN     (N_IN2),
        .N_OUT    (N_OUT2),
        .IN_BASE  (IN_B2),
        .OUT_BASE (OUT_B2)
    ) dut2 (
        .clk                  (clk),
        .rst_n                (rst_n),
        .layer_en_i           (en2),
        .layer_done_o         (d2_done),
        .data_from_buf_addr_o (d2_rd_addr),
        .data_from_buf_i      (d2_rd_data),
        .kernel_addr_o        (d2_kaddr),
        .kernel_data_i        (d2_kdata),
        .bias_addr_o          (d2_baddr),
        .bias_data_i          (d2_bdata),
        .data_to_calc_o       (d2_cdata),
        .calc_valid_o         (d2_cvo),
        .data_from_calc_i     (d2_res),
        .calc_valid_i         (d2_cvi),
        .output_buf_en_o      (d2_wen),
        .data_to_buf_o        (d2_wdata),
        .data_to_buf_addr_o   (d2_waddr)
    );

    // MAC unit behaviour: bias + sum(A[k]*B[k]) in 16-bit wrap-around arithmetic.
    function automatic logic [15:0] calc_fn(input logic [815:0] v);
        logic [15:0] acc = v[15:0];
        for (int k = 0; k < 25; k++) acc = acc + v[416+16*k +: 16] * v[16+16*k +: 16];
        return acc;
    endfunction

    // Reference: neuron o = bias[o] + dot(input vector, kernel rows of o), first nsl slices.
    function automatic logic [15:0] ref_part(input int o, input int nin, input int base,
                                             input int nsl);
        int cc = nin / 25;
        logic [15:0] acc = bmem[o];
        for (int s = 0; s < nsl; s++)
            for (int k = 0; k < 25; k++)
                acc = acc + in_mem[base + 25*s + k] * kmem[o*cc + s][k];
        return acc;
    endfunction

    // Memories with one-cycle read latency
    always @(posedge clk) begin
        for (int l = 0; l < 5; l++) begin
            d1_rd_data[16*l +: 16] <= in_mem[d1_rd_addr[32*l +: 9]];
            d2_rd_data[16*l +: 16] <= in_mem[d2_rd_addr[32*l +: 9]];
        end
        for (int k = 0; k < 25; k++) begin
            d1_kdata[16*k +: 16] <= kmem[d1_kaddr[5:0]][k];
            d2_kdata[16*k +: 16] <= kmem[d2_kaddr[5:0]][k];
        end
        d1_bdata <= bmem[d1_baddr[3:0]];
        d2_bdata <= bmem[d2_baddr[3:0]];
    end

    // MAC responders: lat=1 means the result strobe lands in the first WAIT cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_cvi <= 1'b0;
            d1_cnt <= 0;
            d1_res <= '0;
            d2_cvi <= 1'b0;
            d2_res <= '0;
        end else begin
            cyc    <= cyc + 1;
            d1_cvi <= 1'b0;
            if (d1_cvo) begin
                d1_res <= calc_fn(d1_cdata);
                if (lat <= 1) d1_cvi <= 1'b1;
                else d1_cnt <= lat - 1;
            end else if (d1_cnt != 0) begin
                d1_cnt <= d1_cnt - 1;
                if (d1_cnt == 1) d1_cvi <= 1'b1;
            end
            d2_cvi <= d2_cvo;
            if (d2_cvo) d2_res <= calc_fn(d2_cdata);
        end
    end

    // Monitor for instance 1
    logic [31:0]  wq_addr [$];
    logic [15:0]  wq_data [$];
    int           wq_cyc  [$];
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           issue_cnt = 0;
    int           stab_err = 0;
    bit           wait_mon = 1'b0;
    logic [815:0] snap;

    always @(negedge clk) begin
        if (!rst_n) begin
            snap     <= '0;
            wait_mon <= 1'b0;
        end else if (d1_cvo) begin
            issue_cnt <= issue_cnt + 1;
            snap      <= d1_cdata;
            if (wait_mon) stab_err <= stab_err + 1;
            wait_mon  <= 1'b1;
        end else begin
            if (d1_cdata !== snap) stab_err <= stab_err + 1;
            if (wait_mon && d1_cvi) wait_mon <= 1'b0;
        end
        if (d1_wen) begin
            wq_addr.push_back(d1_waddr);
            wq_data.push_back(d1_wdata);
            wq_cyc.push_back(cyc);
        end
        if (d1_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start1(output int s);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int base_cnt);
        int n = 0;
        while (done_cnt == base_cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_cnt > base_cnt), 1);
    endtask

    task automatic check_run(input int base, input string tag);
        chk({tag, "_nwrites"}, 64'(wq_addr.size() - base), N_OUT);
        for (int o = 0; o < N_OUT; o++) begin
            if (base + o < wq_addr.size()) begin
                chk($sformatf("%s_addr%0d", tag, o), 64'(wq_addr[base+o]), 64'(o));
                chk($sformatf("%s_data%0d", tag, o), 64'(wq_data[base+o]),
                    64'(ref_part(o, N_IN, 0, C)));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, 64'(d1_done), 0);
        chk({tag, "_cvo"}, 64'(d1_cvo), 0);
        chk({tag, "_wen"}, 64'(d1_wen), 0);
        chk({tag, "_rdaddr"}, 64'(d1_rd_addr == '0), 1);
        chk({tag, "_kaddr"}, 64'(d1_kaddr), 0);
        chk({tag, "_baddr"}, 64'(d1_baddr), 0);
        chk({tag, "_cdata"}, 64'(d1_cdata == '0), 1);
        chk({tag, "_wdata"}, 64'(d1_wdata), 0);
        chk({tag, "_waddr"}, 64'(d1_waddr), 0);
    endtask

    initial begin
        int s, s2, wb, db, ib, n;
        for (int i = 0; i < 512; i++) in_mem[i] = 16'($urandom);
        for (int r = 0; r < 64; r++)
            for (int k = 0; k < 25; k++) kmem[r][k] = 16'($urandom);
        for (int i = 0; i < 16; i++) bmem[i] = 16'($urandom);
        rst_n = 1'b0; en = 1'b0; en2 = 1'b0; spur = 1'b0; spur_data = '0; lat = 1;

        // Reset state
        #12;
        chk_zero("reset");
        chk("reset_d2", 64'({d2_done, d2_cvo, d2_wen, d2_kaddr, d2_waddr} == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: zero-wait calc
        wb = wq_addr.size(); db = done_cnt; ib = issue_cnt;
        start1(s);
        chk("r1_lane2_b0", 64'(d1_rd_addr[64 +: 32]), 2);
        to_cyc(s + 1);
        chk("r1_lane0_b1", 64'(d1_rd_addr[0 +: 32]), 5);
        chk("r1_lane4_b1", 64'(d1_rd_addr[128 +: 32]), 9);
        wait_done(db);
        chk("r1_cycles", 64'(done_cyc - s + 1), 331);
        check_run(wb, "r1");
        chk("r1_issues", 64'(issue_cnt - ib), N_OUT * C);
        repeat (2) @(negedge clk);
        chk("r1_done_once", 64'(done_cnt - db), 1);

        // Run 2: five WAIT cycles per slice
        lat = 5;
        wb = wq_addr.size(); db = done_cnt; ib = issue_cnt;
        start1(s);
        wait_done(db);
        check_run(wb, "r2");
        for (int o = 1; o < N_OUT; o++)
            if (wb + o < wq_cyc.size())
                chk($sformatf("r2_neuron_time%0d", o), 64'(wq_cyc[wb+o] - wq_cyc[wb+o-1]), 49);
        chk("r2_issues", 64'(issue_cnt - ib), N_OUT * C);
        chk("r2_stable", 64'(stab_err), 0);

        // Run 3: spurious strobes in FETCH and ISSUE, start pulse mid-run
        lat = 1;
        wb = wq_addr.size(); db = done_cnt;
        start1(s);
        to_cyc(s + 2);  spur = 1'b1; spur_data = 16'($urandom);
        to_cyc(s + 3);  spur = 1'b0;
        to_cyc(s + 6);  spur = 1'b1; spur_data = 16'($urandom);
        to_cyc(s + 7);  spur = 1'b0;
        to_cyc(s + 35); spur = 1'b1; spur_data = 16'($urandom);
        to_cyc(s + 36); spur = 1'b0;
        to_cyc(s + 100); en = 1'b1;
        to_cyc(s + 101); en = 1'b0;
        wait_done(db);
        chk("r3_cycles", 64'(done_cyc - s + 1), 331);
        check_run(wb, "r3");
        repeat (2) @(negedge clk);
        chk("r3_done_once", 64'(done_cnt - db), 1);

        // Run 4: reset during WAIT of neuron 4
        lat = 5;
        wb = wq_addr.size();
        start1(s);
        n = 0;
        while (wq_addr.size() - wb < 4 && n < 1000) begin @(negedge clk); n++; end
        chk("r4_four_writes", 64'(wq_addr.size() - wb), 4);
        n = 0;
        while (!d1_cvo && n < 200) begin @(negedge clk); n++; end
        chk("r4_issue_seen", 64'(d1_cvo), 1);
        repeat (2) @(negedge clk);
        chk("r4_kaddr_pre", 64'(d1_kaddr), 16);
        #1 rst_n = 1'b0;
        #1 chk_zero("r4_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 1;
        repeat (2) @(negedge clk);

        // Run 5: clean restart after reset
        wb = wq_addr.size(); db = done_cnt;
        start1(s);
        chk("r5_lane1_b0", 64'(d1_rd_addr[32 +: 32]), 1);
        chk("r5_lane4_b0", 64'(d1_rd_addr[128 +: 32]), 4);
        to_cyc(s + 1);
        chk("r5_lane0_b1", 64'(d1_rd_addr[0 +: 32]), 5);
        wait_done(db);
        chk("r5_cycles", 64'(done_cyc - s + 1), 331);
        check_run(wb, "r5");

        // Instance 2: addresses and psum chaining with N_IN=50, IN_BASE=200
        @(negedge clk); en2 = 1'b1;
        @(negedge clk); en2 = 1'b0;
        s2 = cyc;
        to_cyc(s2 + 16);
        chk("d2_wen0", 64'(d2_wen), 1);
        chk("d2_waddr0", 64'(d2_waddr), OUT_B2);
        chk("d2_wdata0", 64'(d2_wdata), 64'(ref_part(0, N_IN2, IN_B2, 2)));
        to_cyc(s2 + 27);
        chk("d2_lane3_b2", 64'(d2_rd_addr[96 +: 32]), 238);
        chk("d2_lane0_b2", 64'(d2_rd_addr[0 +: 32]), 235);
        chk("d2_kaddr", 64'(d2_kaddr), 3);
        chk("d2_baddr", 64'(d2_baddr), 1);
        to_cyc(s2 + 31);
        chk("d2_issue", 64'(d2_cvo), 1);
        chk("d2_bias_psum", 64'(d2_cdata[15:0]), 64'(ref_part(1, N_IN2, IN_B2, 1)));
        chk("d2_vecb0", 64'(d2_cdata[16 +: 16]), 64'(kmem[3][0]));
        chk("d2_veca24", 64'(d2_cdata[416+16*24 +: 16]), 64'(in_mem[249]));
        to_cyc(s2 + 33);
        chk("d2_wen1", 64'(d2_wen), 1);
        chk("d2_waddr1", 64'(d2_waddr), OUT_B2 + 1);
        chk("d2_wdata1", 64'(d2_wdata), 64'(ref_part(1, N_IN2, IN_B2, 2)));
        to_cyc(s2 + 34);
        chk("d2_done", 64'(d2_done), 1);

        chk("final_stable", 64'(stab_err), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
